// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Shares the single processor-side port of the SDRAM controller between the
//   instruction-fetch port (read-only) and the data port (read/write).
//   Round-robin arbitration in IDLE, then the granted request is registered
//   onto the controller port and the enable/busy handshake is sequenced:
//     IDLE -> ISSUE (enable up, wait for busy=1)
//          -> WAIT  (wait for busy=0, capture read_data)
//          -> DONE  (one-cycle ack) -> IDLE
//
// Ports
//   clock, reset         : clock, asynchronous active-low reset
//   i_req/i_addr/i_size  : instruction read request (level, held until i_ack)
//   i_ack/i_rdata        : one-cycle completion pulse / last instruction read data
//   d_req/d_wr/d_addr/d_size/d_wdata : data request (level, held until d_ack)
//   d_ack/d_rdata        : one-cycle completion pulse / last data read data
//   rd_enable/wr_enable/address/rd_wr_size/write_data : to controller
//   busy/read_data       : from controller (read_data valid once busy falls)
//   arb_busy             : high whenever the arbiter is not in IDLE
//
// DATA_WIDTH has to stay 64: rd_wr_size tops out at a double-word.

module sdram_arbiter #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [1:0]            i_size,
  output logic                  i_ack,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_wr,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [1:0]            d_size,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  rd_enable,
  output logic                  wr_enable,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [1:0]            rd_wr_size,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic                  busy,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  arb_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t state;
  logic   last_d;   // last grant went to the data port
  logic   gnt_d;    // current transaction belongs to the data port
  logic   gnt_rd;   // current transaction is a read (capture read_data)

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_d     <= 1'b1;  // so the instruction port wins the first tie
      gnt_d      <= 1'b0;
      gnt_rd     <= 1'b0;
      rd_enable  <= 1'b0;
      wr_enable  <= 1'b0;
      address    <= '0;
      rd_wr_size <= '0;
      write_data <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      arb_busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Instruction port wins when alone, or on a tie if data went last.
          if (i_req && (!d_req || last_d)) begin
            address    <= i_addr;
            rd_wr_size <= i_size;
            rd_enable  <= 1'b1;
            gnt_d      <= 1'b0;
            gnt_rd     <= 1'b1;
            last_d     <= 1'b0;
            arb_busy   <= 1'b1;
            state      <= ISSUE;
          end else if (d_req) begin
            address    <= d_addr;
            rd_wr_size <= d_size;
            write_data <= d_wdata;
            rd_enable  <= ~d_wr;
            wr_enable  <= d_wr;
            gnt_d      <= 1'b1;
            gnt_rd     <= ~d_wr;
            last_d     <= 1'b1;
            arb_busy   <= 1'b1;
            state      <= ISSUE;
          end
        end
        // Controller port is held stable; no timeout by design.
        ISSUE: if (busy) state <= WAIT;
        WAIT: begin
          if (!busy) begin
            rd_enable <= 1'b0;
            wr_enable <= 1'b0;
            if (gnt_d) begin
              d_ack <= 1'b1;
              if (gnt_rd) d_rdata <= read_data;
            end else begin
              i_ack   <= 1'b1;
              i_rdata <= read_data;
            end
            state <= DONE;
          end
        end
        // DONE plus the following IDLE keep the enables low for >= 2 cycles.
        DONE: begin
          i_ack    <= 1'b0;
          d_ack    <= 1'b0;
          arb_busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: table of single transactions plus hand-written
// stall, back-to-back, mid-transaction reset and tie-break sequences.
// Expected results go into a scoreboard queue when a request is driven and
// are compared when the matching ack appears.

module tb_sdram_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [25:0] i_addr = '0;
  logic [1:0]  i_size = '0;
  logic        i_ack;
  logic [63:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_wr = 1'b0;
  logic [25:0] d_addr = '0;
  logic [1:0]  d_size = '0;
  logic [63:0] d_wdata = '0;
  logic        d_ack;
  logic [63:0] d_rdata;
  logic        rd_enable, wr_enable;
  logic [25:0] address;
  logic [1:0]  rd_wr_size;
  logic [63:0] write_data;
  logic        busy = 1'b0;
  logic [63:0] read_data = '0;
  logic        arb_busy;

  sdram_arbiter #(.ADDR_WIDTH(26), .DATA_WIDTH(64)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_size(i_size), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_size(d_size), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .rd_enable(rd_enable), .wr_enable(wr_enable), .address(address),
    .rd_wr_size(rd_wr_size), .write_data(write_data),
    .busy(busy), .read_data(read_data), .arb_busy(arb_busy)
  );

  always #5 clock = ~clock;

  // Controller model: busy rises the cycle after an enable is seen, stays
  // high busy_len cycles, then falls with the memory access done.
  int          busy_len = 1;
  bit          stall = 1'b0;
  logic [63:0] mem [256];
  bit          loaded = 1'b0;
  int          cnt = 0;
  logic        done_m = 1'b0;

  always @(posedge clock) begin
    if (!loaded) begin
      for (int m = 0; m < 256; m++) mem[m] <= '0;
      mem[8'h24] <= 64'h0123456789ABCDEF;
      loaded <= 1'b1;
    end
    if (!reset) begin
      busy   <= 1'b0;
      done_m <= 1'b0;
      cnt    <= 0;
    end else begin
      if (!(rd_enable | wr_enable)) done_m <= 1'b0;
      if (!busy && !done_m && (rd_enable | wr_enable) && !stall) begin
        busy <= 1'b1;
        cnt  <= busy_len - 1;
      end else if (busy) begin
        if (cnt == 0) begin
          busy   <= 1'b0;
          done_m <= 1'b1;
          if (wr_enable) mem[address[7:0]] <= write_data;
          else           read_data <= mem[address[7:0]];
        end else cnt <= cnt - 1;
      end
    end
  end

  // Scoreboard and bookkeeping
  typedef struct { bit is_d; logic [63:0] rdata; } sb_t;
  sb_t sb[$];

  typedef struct {
    bit is_d; bit wr; logic [25:0] addr; logic [1:0] size;
    logic [63:0] wdata; logic [63:0] rdata; int blen;
  } vec_t;
  vec_t vt [7];

  int          n_pass = 0, n_total = 0, n_acks = 0;
  logic [63:0] d_exp = '0;
  bit          hold_i = 1'b0, hold_d = 1'b0;
  bit          prev_en = 1'b0, seen_en = 1'b0, prev_ack = 1'b0;
  int          low_cnt = 0;
  int          t, k, a0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One cycle: sample at negedge, run invariant checks, retire any ack.
  task automatic cyc();
    logic en;
    sb_t  e;
    @(negedge clock);
    chk("ack_excl", 64'(i_ack & d_ack), 64'(0));
    chk("en_excl", 64'(rd_enable & wr_enable), 64'(0));
    if (prev_ack) chk("ack_pulse", 64'(i_ack | d_ack), 64'(0));
    en = rd_enable | wr_enable;
    if (en && !prev_en && seen_en) chk("en_gap", 64'(low_cnt >= 2), 64'(1));
    low_cnt = en ? 0 : low_cnt + 1;
    prev_en = en;
    seen_en = seen_en | en;
    prev_ack = i_ack | d_ack;
    if (i_ack | d_ack) begin
      n_acks++;
      if (sb.size() == 0) chk("sb_unexpected", 64'(sb.size()), 64'(1));
      else begin
        e = sb.pop_front();
        chk("ack_port", 64'(d_ack), 64'(e.is_d));
        if (e.is_d) begin
          chk("d_rdata", d_rdata, e.rdata);
          d_exp = e.rdata;
        end else chk("i_rdata", i_rdata, e.rdata);
      end
      if (i_ack && !hold_i) i_req = 1'b0;
      if (d_ack && !hold_d) d_req = 1'b0;
    end
  endtask

  task automatic wait_acks(input int n, input int budget);
    int tgt = n_acks + n;
    int c = 0;
    while (n_acks < tgt && c < budget) begin cyc(); c++; end
    chk("ack_timeout", 64'(n_acks >= tgt), 64'(1));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_en"}, 64'(rd_enable), 64'(0));
    chk({tag, "_wr_en"}, 64'(wr_enable), 64'(0));
    chk({tag, "_addr"}, 64'(address), 64'(0));
    chk({tag, "_size"}, 64'(rd_wr_size), 64'(0));
    chk({tag, "_wdata"}, write_data, 64'(0));
    chk({tag, "_i_ack"}, 64'(i_ack), 64'(0));
    chk({tag, "_d_ack"}, 64'(d_ack), 64'(0));
    chk({tag, "_i_rdata"}, i_rdata, 64'(0));
    chk({tag, "_d_rdata"}, d_rdata, 64'(0));
    chk({tag, "_arb_busy"}, 64'(arb_busy), 64'(0));
  endtask

  task automatic run_vec(input vec_t v);
    int c;
    int a;
    bit w = v.is_d && v.wr;
    busy_len = v.blen;
    if (v.is_d) begin
      d_wr = v.wr; d_addr = v.addr; d_size = v.size; d_wdata = v.wdata; d_req = 1'b1;
    end else begin
      i_addr = v.addr; i_size = v.size; i_req = 1'b1;
    end
    sb.push_back('{v.is_d, w ? d_exp : v.rdata});
    c = 0;
    do begin cyc(); c++; end while (!(rd_enable | wr_enable) && c < 50);
    chk("rd_en", 64'(rd_enable), 64'(!w));
    chk("wr_en", 64'(wr_enable), 64'(w));
    chk("addr", 64'(address), 64'(v.addr));
    chk("size", 64'(rd_wr_size), 64'(v.size));
    if (w) chk("wdata", write_data, v.wdata);
    a = n_acks;
    c = 0;
    while (n_acks == a && c < 100) begin cyc(); c++; end
    chk("latency", 64'(c), 64'(v.blen + 2));
    cyc();
    chk("arb_idle", 64'(arb_busy), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b0, 1'b0, 26'h0000124, 2'b11, 64'h0, 64'h0123456789ABCDEF, 1};
    vt[1] = '{1'b1, 1'b1, 26'h3FFFFFF, 2'b00, 64'hA5, 64'h0, 3};
    vt[2] = '{1'b1, 1'b0, 26'h3FFFFFF, 2'b00, 64'h0, 64'hA5, 2};
    vt[3] = '{1'b0, 1'b0, 26'h3FFFFFF, 2'b10, 64'h0, 64'hA5, 4};
    vt[4] = '{1'b1, 1'b1, 26'h0000010, 2'b11, 64'hDEADBEEFCAFEF00D, 64'h0, 1};
    vt[5] = '{1'b1, 1'b0, 26'h0000010, 2'b11, 64'h0, 64'hDEADBEEFCAFEF00D, 2};
    vt[6] = '{1'b0, 1'b0, 26'h0000200, 2'b01, 64'h0, 64'h0, 1};

    // Reset state
    #2 reset = 1'b0;
    repeat (3) cyc();
    chk_zero("rst");
    reset = 1'b1;
    cyc();

    // Single transactions
    for (int i = 0; i < 7; i++) run_vec(vt[i]);

    // Stall: controller ignores the enable for 20 cycles
    stall = 1'b1; busy_len = 2;
    i_addr = 26'h10; i_size = 2'b11; i_req = 1'b1;
    sb.push_back('{1'b0, 64'hDEADBEEFCAFEF00D});
    t = 0;
    do begin cyc(); t++; end while (!rd_enable && t < 50);
    repeat (20) begin
      cyc();
      chk("stall_en", 64'(rd_enable), 64'(1));
      chk("stall_addr", 64'(address), 64'h10);
      chk("stall_busy", 64'(arb_busy), 64'(1));
    end
    stall = 1'b0;
    wait_acks(1, 100);
    cyc();

    // Back-to-back: d_req held across three writes
    hold_d = 1'b1; busy_len = 2;
    d_wr = 1'b1; d_addr = 26'h40; d_size = 2'b10; d_wdata = 64'h1111;
    repeat (3) sb.push_back('{1'b1, d_exp});
    d_req = 1'b1;
    wait_acks(3, 300);
    d_req = 1'b0; hold_d = 1'b0;
    a0 = n_acks;
    repeat (4) cyc();
    chk("b2b_no_extra", 64'(n_acks), 64'(a0));
    chk("b2b_idle", 64'(arb_busy), 64'(0));

    // Reset while in WAIT with busy high
    busy_len = 10;
    i_addr = 26'h124; i_size = 2'b11; i_req = 1'b1;
    sb.push_back('{1'b0, 64'h0123456789ABCDEF});
    t = 0;
    while (!busy && t < 50) begin cyc(); t++; end
    cyc(); cyc();
    chk("wait_rd_en", 64'(rd_enable), 64'(1));
    chk("wait_arb_busy", 64'(arb_busy), 64'(1));
    reset = 1'b0;
    #1;
    chk_zero("midrst");
    sb.delete();
    d_exp = '0;
    a0 = n_acks;
    repeat (3) cyc();
    chk("midrst_no_ack", 64'(n_acks), 64'(a0));
    reset = 1'b1;
    sb.push_back('{1'b0, 64'h0123456789ABCDEF});
    wait_acks(1, 100);
    cyc();

    // Fresh reset, then ties: instruction, data, instruction, data
    reset = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
    d_exp = '0;
    busy_len = 2;
    i_addr = 26'h124; i_size = 2'b11;
    d_wr = 1'b0; d_addr = 26'h3FFFFFF; d_size = 2'b00;
    hold_i = 1'b1; hold_d = 1'b1;
    sb.push_back('{1'b0, 64'h0123456789ABCDEF});
    sb.push_back('{1'b1, 64'hA5});
    i_req = 1'b1; d_req = 1'b1;
    wait_acks(2, 200);
    i_req = 1'b0; d_req = 1'b0;
    hold_i = 1'b0; hold_d = 1'b0;
    cyc(); cyc();
    sb.push_back('{1'b0, 64'h0123456789ABCDEF});
    sb.push_back('{1'b1, 64'hA5});
    i_req = 1'b1; d_req = 1'b1;
    wait_acks(2, 200);
    cyc(); cyc();
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
